// File: rtl/bus_ram_responder_if.sv
// Data-bus encodings and the core <-> RAM responder bus bundle.
// master = core side, slave = memory side.
package bus_ram_pkg;
    localparam logic [1:0] MEM_ACCESS_NONE = 2'd0;
    localparam logic [1:0] MEM_ACCESS_R    = 2'd1;
    localparam logic [1:0] MEM_ACCESS_W    = 2'd2;
    localparam logic [1:0] MEM_ACCESS_X    = 2'd3;

    localparam logic [1:0] MEM_LEN_B = 2'd0;
    localparam logic [1:0] MEM_LEN_H = 2'd1;
    localparam logic [1:0] MEM_LEN_W = 2'd2;
endpackage

interface bus_ram_responder_if;
    logic [31:0] db_addr;
    logic [1:0]  db_accessType;
    logic [1:0]  db_memLen;
    logic [31:0] db_dataOut;
    logic [31:0] db_dataIn;
    logic        db_ready;
    logic        db_fault;

    modport master (
        output db_addr,
        output db_accessType,
        output db_memLen,
        output db_dataOut,
        input  db_dataIn,
        input  db_ready,
        input  db_fault
    );

    modport slave (
        input  db_addr,
        input  db_accessType,
        input  db_memLen,
        input  db_dataOut,
        output db_dataIn,
        output db_ready,
        output db_fault
    );
endinterface

// File: rtl/bus_ram_responder.sv
// Word-organised RAM behind the core data bus with programmable wait states.
// Define BUS_RAM_ALIGN_CHECK_EN to fault misaligned H/W accesses.
module bus_ram_responder
    import bus_ram_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 1
) (
    input logic clk,
    input logic res,
    bus_ram_responder_if.slave db
);
    localparam int AW = ADDR_BITS + 2;
    localparam logic [3:0] CNT_INIT =
        4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addrQ;
    logic [1:0]    typeQ;
    logic [1:0]    lenQ;
    logic [31:0]   dataQ;
    logic [31:0]   dataIn;
    logic          ready;
    logic          fault;

    logic [31:0] mem [2**ADDR_BITS];

    logic                 live;
    logic                 req;
    logic                 doAccess;
    logic                 isRead;
    logic                 isWrite;
    logic                 misalign;
    logic                 memWe;
    logic [AW-1:0]        accAddr;
    logic [1:0]           accType;
    logic [1:0]           accLen;
    logic [31:0]          accData;
    logic [ADDR_BITS-1:0] wordIdx;
    logic [31:0]          word;
    logic [31:0]          rdLane;
    logic [31:0]          wrData;
    logic [3:0]           be;
    logic                 unusedAddrHi;

    // Upper address bits alias the RAM across the whole space.
    assign unusedAddrHi = ^db.db_addr[31:AW];

    assign req  = db.db_accessType != MEM_ACCESS_NONE;
    assign live = state == IDLE;

    // With no wait states the access happens on the capture edge,
    // so the live bus is used; otherwise the captured copy.
    assign accAddr = live ? db.db_addr[AW-1:0] : addrQ;
    assign accType = live ? db.db_accessType   : typeQ;
    assign accLen  = live ? db.db_memLen       : lenQ;
    assign accData = live ? db.db_dataOut      : dataQ;

    assign doAccess = (live && req && NO_WAIT)
                    || (state == WAIT && cnt == 4'd0);

    assign isRead  = accType == MEM_ACCESS_R
                   || accType == MEM_ACCESS_X;
    assign isWrite = accType == MEM_ACCESS_W;

    assign wordIdx = accAddr[AW-1:2];
    assign word    = mem[wordIdx];

`ifdef BUS_RAM_ALIGN_CHECK_EN
    assign misalign =
        (accLen == MEM_LEN_H && accAddr[0])
        || (accLen == MEM_LEN_W && accAddr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        be     = 4'b0000;
        wrData = accData;
        rdLane = 32'h0;
        unique case (1'b1)
            accLen == MEM_LEN_B: begin
                be     = 4'b0001 << accAddr[1:0];
                wrData = {4{accData[7:0]}};
                rdLane = {24'h0,
                          word[{accAddr[1:0], 3'b000} +: 8]};
            end
            accLen == MEM_LEN_H: begin
                be     = accAddr[1] ? 4'b1100 : 4'b0011;
                wrData = {2{accData[15:0]}};
                rdLane = {16'h0,
                          word[{accAddr[1], 4'b0000} +: 16]};
            end
            accLen == MEM_LEN_W: begin
                be     = 4'b1111;
                rdLane = word;
            end
            default: ;
        endcase
    end

    // A commit coinciding with reset is dropped.
    assign memWe = doAccess && isWrite && !misalign && !res;

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            ready  <= 1'b0;
            fault  <= 1'b0;
            dataIn <= 32'h0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addrQ <= db.db_addr[AW-1:0];
                        typeQ <= db.db_accessType;
                        lenQ  <= db.db_memLen;
                        dataQ <= db.db_dataOut;
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (doAccess) begin
                ready <= 1'b1;
                fault <= misalign;
                if (misalign) begin
                    dataIn <= 32'h0;
                end else if (isRead) begin
                    dataIn <= rdLane;
                end
            end
        end
    end

    assign db.db_dataIn = dataIn;
    assign db.db_ready  = ready;
    assign db.db_fault  = fault;

endmodule
